gf_syndrome_ctrl: RTL and testbench



---
 rtl/gf_syndrome_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gf_syndrome_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gf_syndrome_ctrl.sv
// BCH syndrome frame controller: streams LSB-first codeword words through pSYND_NUM Horner engines.
// Optional ieop/oerr framing check is built when GF_SYNDROME_CTRL_EOP_CHECK_EN is defined.
module gf_syndrome_ctrl #(
    parameter int m         = 4,
    parameter int irrpol    = 19,
    parameter int pN        = 15,
    parameter int pDAT_W    = 4,
    parameter int pSYND_NUM = 4
) (
    input  logic                   iclk,
    input  logic                   ireset_n,
    input  logic                   iclkena,
    input  logic                   ival,
    input  logic                   isop,
    input  logic [pDAT_W-1:0]      idat,
`ifdef GF_SYNDROME_CTRL_EOP_CHECK_EN
    input  logic                   ieop,
    output logic                   oerr,
`endif
    output logic                   ordy,
    output logic                   oval,
    input  logic                   irdy,
    output logic [pSYND_NUM*m-1:0] osyndrome,
    output logic                   ozero
);

    localparam int cWORD_NUM = (pN + pDAT_W - 1) / pDAT_W;
    localparam int cREM      = pN % pDAT_W;
    localparam logic [pDAT_W-1:0] cLAST_MASK =
        (cREM == 0) ? {pDAT_W{1'b1}} : pDAT_W'((1 << cREM) - 1);
    localparam int cCNT_W = $clog2(cWORD_NUM + 1);
    localparam logic [cCNT_W-1:0] cLAST_IDX = cCNT_W'(cWORD_NUM - 1);
    localparam logic [m-1:0] cPOLY = m'(irrpol);

    function automatic logic [m-1:0] mul_x(input logic [m-1:0] a);
        logic [m-1:0] s;
        s = a << 1;
        return a[m-1] ? (s ^ cPOLY) : s;
    endfunction

    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] r;
        logic [m-1:0] p;
        r = '0;
        p = a;
        for (int k = 0; k < m; k++) begin
            if (b[k]) r = r ^ p;
            p = mul_x(p);
        end
        return r;
    endfunction

    function automatic logic [m-1:0] alpha_pow(input int e);
        logic [m-1:0] r;
        r = m'(1);
        for (int k = 0; k < e; k++) r = mul_x(r);
        return r;
    endfunction

    function automatic logic [pSYND_NUM*m-1:0] alpha_table();
        logic [pSYND_NUM*m-1:0] t;
        t = '0;
        for (int i = 0; i < pSYND_NUM; i++) t[i*m +: m] = alpha_pow(i + 1);
        return t;
    endfunction

    localparam logic [pSYND_NUM*m-1:0] cALPHA = alpha_table();

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        ACC      = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t                 state;
    logic [cCNT_W-1:0]      word_cnt;
    logic [pSYND_NUM*m-1:0] acc;
    logic [pSYND_NUM*m-1:0] acc_nxt;
    logic [m-1:0]           eng_a;
    logic [cCNT_W-1:0]      word_idx;
    logic [pDAT_W-1:0]      mask;
    logic                   accept;
    logic                   frame_word;
    logic                   last_word;
    logic                   out_free;

    assign ordy       = (state != HOLD);
    assign accept     = ival & ordy & iclkena;
    // An isop word is always word 0, whether it starts or restarts a frame.
    assign frame_word = accept & (isop | (state == ACC));
    assign word_idx   = isop ? '0 : word_cnt;
    assign last_word  = (word_idx == cLAST_IDX);
    assign mask       = last_word ? cLAST_MASK : {pDAT_W{1'b1}};
    assign out_free   = ~oval | irdy;

    always_comb begin
        acc_nxt = '0;
        eng_a   = '0;
        for (int i = 0; i < pSYND_NUM; i++) begin
            eng_a = acc[i*m +: m];
            for (int b = 0; b < pDAT_W; b++) begin
                if (mask[b]) begin
                    if (isop && b == 0) eng_a = m'(idat[b]);
                    else                eng_a = gf_mul(eng_a, cALPHA[i*m +: m]) ^ m'(idat[b]);
                end
            end
            acc_nxt[i*m +: m] = eng_a;
        end
    end

`ifdef GF_SYNDROME_CTRL_EOP_CHECK_EN
    logic err_q;
    logic err_nxt;
    // ieop must coincide exactly with the last word; a restart taints the next vector.
    assign err_nxt = (isop ? (state == ACC) : err_q) | (ieop ^ last_word);
`endif

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            state     <= WAIT_SOP;
            word_cnt  <= '0;
            acc       <= '0;
            oval      <= 1'b0;
            osyndrome <= '0;
            ozero     <= 1'b0;
`ifdef GF_SYNDROME_CTRL_EOP_CHECK_EN
            err_q     <= 1'b0;
            oerr      <= 1'b0;
`endif
        end else if (iclkena) begin
            if (oval && irdy) oval <= 1'b0;
            case (state)
                WAIT_SOP, ACC: begin
                    if (frame_word) begin
                        acc <= acc_nxt;
`ifdef GF_SYNDROME_CTRL_EOP_CHECK_EN
                        err_q <= err_nxt;
`endif
                        if (last_word) begin
                            word_cnt <= '0;
                            if (out_free) begin
                                oval      <= 1'b1;
                                osyndrome <= acc_nxt;
                                ozero     <= (acc_nxt == '0);
`ifdef GF_SYNDROME_CTRL_EOP_CHECK_EN
                                oerr      <= err_nxt;
`endif
                                state     <= WAIT_SOP;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            word_cnt <= word_idx + 1'b1;
                            state    <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (irdy) begin
                        oval      <= 1'b1;
                        osyndrome <= acc;
                        ozero     <= (acc == '0);
`ifdef GF_SYNDROME_CTRL_EOP_CHECK_EN
                        oerr      <= err_q;
`endif
                        state     <= WAIT_SOP;
                    end
                end
                default: state <= WAIT_SOP;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_syndrome_ctrl.sv
// Self-checking bench for gf_syndrome_ctrl (default build): per-cycle compare against a frame-level model.
module tb_gf_syndrome_ctrl;

    logic        iclk;
    logic        ireset_n;
    logic        iclkena;
    logic        ival;
    logic        isop;
    logic [3:0]  idat;
    logic        ordy;
    logic        oval;
    logic        irdy;
    logic [15:0] osyndrome;
    logic        ozero;

    int n_checks = 0;
    int n_pass   = 0;

    gf_syndrome_ctrl dut (
        .iclk      (iclk),
        .ireset_n  (ireset_n),
        .iclkena   (iclkena),
        .ival      (ival),
        .isop      (isop),
        .idat      (idat),
        .ordy      (ordy),
        .oval      (oval),
        .irdy      (irdy),
        .osyndrome (osyndrome),
        .ozero     (ozero)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference arithmetic: syndrome = sum over set bits of alpha^((i+1)*degree).
    function automatic logic [3:0] gf_exp(input int e);
        logic [3:0] v;
        v = 4'd1;
        for (int k = 0; k < e % 15; k++) v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
        return v;
    endfunction

    function automatic logic [15:0] syn_of(input logic [14:0] bits);
        logic [15:0] r;
        logic [3:0]  s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = '0;
            for (int k = 0; k < 15; k++)
                if (bits[k]) s = s ^ gf_exp((i + 1) * (14 - k));
            r[i*4 +: 4] = s;
        end
        return r;
    endfunction

    // Frame-level model state
    bit          m_hold;
    bit          m_in_frame;
    bit          m_oval;
    bit          m_zero;
    logic [15:0] m_syn;
    logic [15:0] m_hold_vec;
    bit          fbits[$];

    task automatic model_step();
        bit          free;
        bit          hs;
        bit          load;
        logic [15:0] vec;
        logic [14:0] packed_bits;
        load = 0;
        vec  = '0;
        if (!ireset_n) begin
            m_hold = 0; m_in_frame = 0; m_oval = 0; m_zero = 0;
            m_syn = '0; m_hold_vec = '0;
            fbits.delete();
        end else if (iclkena) begin
            free = !m_oval || irdy;
            hs   = m_oval && irdy;
            if (m_hold) begin
                if (irdy) begin
                    load = 1; vec = m_hold_vec; m_hold = 0;
                end
            end else if (ival) begin
                if (isop) begin
                    fbits.delete();
                    m_in_frame = 1;
                end
                if (m_in_frame) begin
                    for (int b = 0; b < 4; b++) fbits.push_back(idat[b]);
                    if (fbits.size() == 16) begin
                        for (int k = 0; k < 15; k++) packed_bits[k] = fbits[k];
                        vec = syn_of(packed_bits);
                        m_in_frame = 0;
                        fbits.delete();
                        if (free) load = 1;
                        else begin
                            m_hold = 1; m_hold_vec = vec;
                        end
                    end
                end
            end
            if (load) begin
                m_oval = 1; m_syn = vec; m_zero = (vec == '0);
            end else if (hs) begin
                m_oval = 0;
            end
        end
    endtask

    // Compare current outputs, then advance the model across the coming edge.
    always @(negedge iclk) begin
        check("ordy", {31'd0, ordy}, {31'd0, !m_hold});
        check("oval", {31'd0, oval}, {31'd0, m_oval});
        if (m_oval) begin
            check("osyndrome", {16'd0, osyndrome}, {16'd0, m_syn});
            check("ozero", {31'd0, ozero}, {31'd0, m_zero});
        end
        model_step();
    end

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle(input int n);
        ival = 0; isop = 0;
        repeat (n) step();
    endtask

    task automatic word(input logic s, input logic [3:0] d);
        ival = 1; isop = s; idat = d;
        step();
    endtask

    task automatic frame(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
        word(1, d0); word(0, d1); word(0, d2); word(0, d3);
    endtask

    initial begin
        ireset_n = 0; iclkena = 1; ival = 0; isop = 0; idat = '0; irdy = 1;

        // Model pins against hand-computed GF(16) values
        check("pin_x14", {16'd0, syn_of(15'h0001)}, 32'h0000EFD9);
        check("pin_x13", {16'd0, syn_of(15'h0002)}, 32'h0000BAED);
        check("pin_x0",  {16'd0, syn_of(15'h4000)}, 32'h00001111);
        check("pin_zero", {16'd0, syn_of(15'h0000)}, 32'h00000000);

        repeat (2) step();
        ireset_n = 1;
        idle(2);

        frame(4'h0, 4'h0, 4'h0, 4'h0); idle(3);
        frame(4'h1, 4'h0, 4'h0, 4'h0); idle(3);
        frame(4'h0, 4'h0, 4'h0, 4'h4); idle(3);
        frame(4'h0, 4'h0, 4'h0, 4'h8); idle(3);

        // Back-to-back with downstream stalled
        irdy = 0;
        frame(4'h0, 4'h2, 4'h0, 4'h0);
        frame(4'h5, 4'hA, 4'h3, 4'h7);
        idle(4);
        irdy = 1;
        idle(4);

        // Mid-frame restart followed by a clean frame
        word(1, 4'h5); word(0, 4'h3);
        frame(4'h0, 4'h0, 4'h0, 4'h0); idle(3);

        // Reset during ACC, then during a pending vector
        word(1, 4'h9); word(0, 4'h6);
        ireset_n = 0; idle(1); ireset_n = 1;
        frame(4'h3, 4'h0, 4'hC, 4'h1);
        irdy = 0; idle(2);
        ireset_n = 0; idle(1); ireset_n = 1; irdy = 1;
        frame(4'h0, 4'h1, 4'h0, 4'h2); idle(3);

        // Randomized traffic
        begin
            int pos;
            pos = 0;
            for (int c = 0; c < 3000; c++) begin
                iclkena  = ($urandom_range(0, 9) != 0);
                ireset_n = ($urandom_range(0, 399) != 0);
                irdy     = ($urandom_range(0, 2) != 0);
                ival     = ($urandom_range(0, 3) != 0);
                idat     = 4'($urandom_range(0, 15));
                isop     = (pos == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 29) == 0);
                if (ival) pos = (pos + 1) % 4;
                step();
            end
        end
        ireset_n = 1; iclkena = 1; irdy = 1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
